syncfifo_ex: RTL and testbench

SYNCFIFO_EX -- requirements
Module: syncfifo_ex

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/syncfifo_ex_if.sv | 35 +++
 rtl/fifo_dpram.sv | 33 +++
 rtl/syncfifo_ex.sv | 115 +++++++++++
 tb/tb_syncfifo_ex.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Sizing helpers and flag bundle shared by the syncfifo_ex slice.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

  // Occupancy needs one bit more than the address so that WORDS itself is representable.
  function automatic int usedw_width(input int depth);
    return depth + 1;
  endfunction

  function automatic int af_default(input int depth);
    return (2 ** depth) - 4;
  endfunction

  function automatic int ae_default();
    return 4;
  endfunction

  typedef struct packed {
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    almost_empty: 1'b1,
    almost_full:  1'b0,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage
`default_nettype wire

// File: rtl/syncfifo_ex_if.sv
`default_nettype none
// ============================================================================
// Module   : syncfifo_ex_if
// Brief    : Write/read handshake, data and status bundle of the sync FIFO.
// Revision : 1.0
// ============================================================================
interface syncfifo_ex_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
);

  logic [WIDTH-1:0] data;
  logic             wrreq;
  logic             rdreq;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [DEPTH:0]   usedw;
  logic             overflow;
  logic             underflow;

  modport master (
    output data, wrreq, rdreq,
    input  q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_dpram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_dpram
// Brief    : FIFO storage: one synchronous write port, one asynchronous read port.
// Revision : 1.0
// ============================================================================
module fifo_dpram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int WORDS = 2 ** DEPTH;

  // Contents are deliberately never reset; only the FIFO pointers are.
  logic [WIDTH-1:0] r_mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/syncfifo_ex.sv
`default_nettype none
// ============================================================================
// Module   : syncfifo_ex
// Brief    : Single-clock FIFO with exact occupancy, threshold and error flags.
// Revision : 1.0
// ============================================================================
module syncfifo_ex
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 10,
  parameter int SHOWAHEAD = 1,
  parameter int AF_LEVEL  = af_default(DEPTH),
  parameter int AE_LEVEL  = ae_default()
) (
  input logic         clock,
  input logic         aclr,
  syncfifo_ex_if.slave bus
);

  localparam int WORDS = 2 ** DEPTH;
  localparam int UW    = usedw_width(DEPTH);

  localparam logic [UW-1:0] AF_THR = UW'(AF_LEVEL);
  localparam logic [UW-1:0] AE_THR = UW'(AE_LEVEL);

  generate
    if ((AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > WORDS)) begin : g_param_check
      $error("syncfifo_ex: need AE_LEVEL < AF_LEVEL <= 2**DEPTH");
    end
  endgenerate

  logic [UW-1:0]    r_wr_ptr;
  logic [UW-1:0]    r_rd_ptr;
  logic [UW-1:0]    r_usedw;
  fifo_flags_t      r_flags;

  logic [UW-1:0]    w_wr_ptr_nxt;
  logic [UW-1:0]    w_rd_ptr_nxt;
  logic [UW-1:0]    w_usedw_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_rd_data;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH] != r_rd_ptr[DEPTH]) &&
                   (r_wr_ptr[DEPTH-1:0] == r_rd_ptr[DEPTH-1:0]);

  // A read frees the slot the write lands in, so a full FIFO still takes write+read.
  assign w_rd_acc = bus.rdreq & ~w_empty & ~aclr;
  assign w_wr_acc = bus.wrreq & (~w_full | w_rd_acc) & ~aclr;

  assign w_wr_ptr_nxt = r_wr_ptr + UW'(w_wr_acc);
  assign w_rd_ptr_nxt = r_rd_ptr + UW'(w_rd_acc);
  assign w_usedw_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  always_ff @(posedge clock) begin
    if (aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_flags  <= FLAGS_RESET;
    end else begin
      r_wr_ptr             <= w_wr_ptr_nxt;
      r_rd_ptr             <= w_rd_ptr_nxt;
      r_usedw              <= w_usedw_nxt;
      r_flags.almost_full  <= (w_usedw_nxt >= AF_THR);
      r_flags.almost_empty <= (w_usedw_nxt <= AE_THR);
      r_flags.overflow     <= bus.wrreq & w_full & ~bus.rdreq;
      r_flags.underflow    <= bus.rdreq & w_empty;
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr[DEPTH-1:0]),
    .wdata (bus.data),
    .raddr (r_rd_ptr[DEPTH-1:0]),
    .rdata (w_rd_data)
  );

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      assign bus.q = w_rd_data;
    end else begin : g_registered
      logic [WIDTH-1:0] r_q;

      always_ff @(posedge clock) begin
        if (aclr) begin
          r_q <= '0;
        end else if (w_rd_acc) begin
          r_q <= w_rd_data;
        end
      end

      assign bus.q = r_q;
    end
  endgenerate

  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.usedw        = r_usedw;
  assign bus.almost_full  = r_flags.almost_full;
  assign bus.almost_empty = r_flags.almost_empty;
  assign bus.overflow     = r_flags.overflow;
  assign bus.underflow    = r_flags.underflow;

endmodule
`default_nettype wire

// File: tb/tb_syncfifo_ex.sv
`default_nettype none
// ============================================================================
// Module   : tb_syncfifo_ex
// Brief    : Self-checking bench driving a show-ahead and a registered FIFO in lockstep.
// Revision : 1.0
// ============================================================================
module tb_syncfifo_ex;

  localparam int W = 16;
  localparam int D = 3;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         aclr;
  logic [W-1:0] data;
  logic         wrreq;
  logic         rdreq;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] rq_exp;
  logic         exp_ovf;
  logic         exp_udf;

  always #5 clock = ~clock;

  syncfifo_ex_if #(.WIDTH(W), .DEPTH(D)) sa_if ();
  syncfifo_ex_if #(.WIDTH(W), .DEPTH(D)) rg_if ();

  assign sa_if.data  = data;
  assign sa_if.wrreq = wrreq;
  assign sa_if.rdreq = rdreq;
  assign rg_if.data  = data;
  assign rg_if.wrreq = wrreq;
  assign rg_if.rdreq = rdreq;

  syncfifo_ex #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(1), .AF_LEVEL(6), .AE_LEVEL(2)) dut_sa (
    .clock (clock),
    .aclr  (aclr),
    .bus   (sa_if)
  );

  syncfifo_ex #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(0), .AF_LEVEL(6), .AE_LEVEL(2)) dut_rg (
    .clock (clock),
    .aclr  (aclr),
    .bus   (rg_if)
  );

  // Drives one clock of stimulus and advances the reference model across that edge.
  task automatic cycle(input logic c, input logic w, input logic [W-1:0] d, input logic r);
    bit m_empty, m_full, ra, wa;
    aclr  = c;
    wrreq = w;
    data  = d;
    rdreq = r;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == N);
    ra = !c && r && !m_empty;
    wa = !c && w && (!m_full || ra);
    @(posedge clock);
    if (c) begin
      mq.delete();
      rq_exp  = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      if (ra) rq_exp = mq.pop_front();
      if (wa) mq.push_back(d);
      exp_ovf = w && m_full && !r;
      exp_udf = r && m_empty;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b1);
    vectors++; if (sa_if.usedw !== 4'd0) begin miscompares++; $display("FAIL reset_usedw: got %0d want 0", sa_if.usedw); end
    vectors++; if (sa_if.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", sa_if.empty); end
    vectors++; if (sa_if.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", sa_if.full); end
    vectors++; if (sa_if.almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae: got %b want 1", sa_if.almost_empty); end
    vectors++; if (sa_if.almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af: got %b want 0", sa_if.almost_full); end
    vectors++; if ({sa_if.overflow, sa_if.underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b want 00", {sa_if.overflow, sa_if.underflow}); end
    vectors++; if (rg_if.q !== 16'h0000) begin miscompares++; $display("FAIL reset_qreg: got %h want 0000", rg_if.q); end
  endtask

  task automatic test_fill_overflow();
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b1, W'(i), 1'b0);
      vectors++; if (sa_if.usedw !== 4'(i + 1)) begin miscompares++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, sa_if.usedw, i + 1); end
      vectors++; if (sa_if.almost_full !== (i + 1 >= 6)) begin miscompares++; $display("FAIL fill_af[%0d]: got %b want %b", i, sa_if.almost_full, (i + 1 >= 6)); end
    end
    vectors++; if (sa_if.full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", sa_if.full); end
    cycle(1'b0, 1'b1, 16'h0008, 1'b0);
    vectors++; if (sa_if.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse: got %b want 1", sa_if.overflow); end
    vectors++; if (sa_if.usedw !== 4'd8) begin miscompares++; $display("FAIL ovf_usedw: got %0d want 8", sa_if.usedw); end
    vectors++; if (sa_if.q !== 16'h0000) begin miscompares++; $display("FAIL ovf_head: got %h want 0000", sa_if.q); end
    cycle(1'b0, 1'b0, '0, 1'b0);
    vectors++; if (sa_if.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", sa_if.overflow); end
  endtask

  task automatic test_back_to_back_wrap();
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, W'(16'h0200 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, W'(16'h0300 + i), 1'b1);
      vectors++; if ({sa_if.full, sa_if.usedw} !== {1'b1, 4'd8}) begin miscompares++; $display("FAIL wrap_full[%0d]: got full=%b usedw=%0d want full=1 usedw=8", i, sa_if.full, sa_if.usedw); end
      vectors++; if (rg_if.q !== rq_exp) begin miscompares++; $display("FAIL wrap_qreg[%0d]: got %h want %h", i, rg_if.q, rq_exp); end
      vectors++; if (sa_if.q !== mq[0]) begin miscompares++; $display("FAIL wrap_head[%0d]: got %h want %h", i, sa_if.q, mq[0]); end
    end
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      vectors++; if (rg_if.q !== W'(16'h030C + i)) begin miscompares++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, rg_if.q, W'(16'h030C + i)); end
    end
    vectors++; if (sa_if.empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b want 1", sa_if.empty); end
  endtask

  task automatic test_showahead();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 16'h00A5, 1'b0);
    vectors++; if (sa_if.empty !== 1'b0) begin miscompares++; $display("FAIL sa_empty: got %b want 0", sa_if.empty); end
    vectors++; if (sa_if.q !== 16'h00A5) begin miscompares++; $display("FAIL sa_q: got %h want 00a5", sa_if.q); end
    cycle(1'b0, 1'b0, '0, 1'b1);
    vectors++; if ({sa_if.empty, sa_if.usedw} !== {1'b1, 4'd0}) begin miscompares++; $display("FAIL sa_ack: got empty=%b usedw=%0d want empty=1 usedw=0", sa_if.empty, sa_if.usedw); end
    vectors++; if (rg_if.q !== 16'h00A5) begin miscompares++; $display("FAIL sa_qreg: got %h want 00a5", rg_if.q); end
  endtask

  task automatic test_underflow();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0055, 1'b1);
    vectors++; if (sa_if.underflow !== 1'b1) begin miscompares++; $display("FAIL udf_pulse: got %b want 1", sa_if.underflow); end
    vectors++; if ({sa_if.usedw, sa_if.empty} !== {4'd1, 1'b0}) begin miscompares++; $display("FAIL udf_write: got usedw=%0d empty=%b want usedw=1 empty=0", sa_if.usedw, sa_if.empty); end
    cycle(1'b0, 1'b0, '0, 1'b0);
    vectors++; if (sa_if.underflow !== 1'b0) begin miscompares++; $display("FAIL udf_clear: got %b want 0", sa_if.underflow); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, W'(16'h0040 + i), 1'b0);
    vectors++; if (sa_if.usedw !== 4'd5) begin miscompares++; $display("FAIL mid_pre: got %0d want 5", sa_if.usedw); end
    cycle(1'b1, 1'b1, 16'h0077, 1'b0);
    vectors++; if ({sa_if.usedw, sa_if.empty} !== {4'd0, 1'b1}) begin miscompares++; $display("FAIL mid_clear: got usedw=%0d empty=%b want usedw=0 empty=1", sa_if.usedw, sa_if.empty); end
    cycle(1'b0, 1'b1, 16'h0033, 1'b0);
    vectors++; if ({sa_if.usedw, sa_if.q} !== {4'd1, 16'h0033}) begin miscompares++; $display("FAIL mid_first: got usedw=%0d q=%h want usedw=1 q=0033", sa_if.usedw, sa_if.q); end
    cycle(1'b0, 1'b0, '0, 1'b1);
    vectors++; if ({sa_if.empty, rg_if.q} !== {1'b1, 16'h0033}) begin miscompares++; $display("FAIL mid_drain: got empty=%b q=%h want empty=1 q=0033", sa_if.empty, rg_if.q); end
  endtask

  task automatic test_registered();
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, W'(i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      vectors++; if (rg_if.q !== W'(i)) begin miscompares++; $display("FAIL reg_q[%0d]: got %h want %h", i, rg_if.q, W'(i)); end
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    vectors++; if (rg_if.q !== 16'h0003) begin miscompares++; $display("FAIL reg_hold: got %h want 0003", rg_if.q); end
  endtask

  task automatic test_random();
    int wp;
    logic c, w, r;
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int n = 0; n < 10000; n++) begin
      case ((n / 300) % 3)
        0:       wp = 80;
        1:       wp = 50;
        default: wp = 20;
      endcase
      c = ($urandom_range(0, 999) == 0);
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < (100 - wp));
      cycle(c, w, W'($urandom), r);
      vectors++; if (sa_if.usedw !== 4'(mq.size())) begin miscompares++; $display("FAIL rnd_usedw@%0d: got %0d want %0d", n, sa_if.usedw, mq.size()); end
      vectors++; if ({sa_if.empty, sa_if.full} !== {mq.size() == 0, mq.size() == N}) begin miscompares++; $display("FAIL rnd_ef@%0d: got %b%b want %b%b", n, sa_if.empty, sa_if.full, mq.size() == 0, mq.size() == N); end
      vectors++; if ({sa_if.almost_empty, sa_if.almost_full} !== {mq.size() <= 2, mq.size() >= 6}) begin miscompares++; $display("FAIL rnd_thr@%0d: got %b%b want %b%b", n, sa_if.almost_empty, sa_if.almost_full, mq.size() <= 2, mq.size() >= 6); end
      vectors++; if ({sa_if.overflow, sa_if.underflow} !== {exp_ovf, exp_udf}) begin miscompares++; $display("FAIL rnd_err@%0d: got %b%b want %b%b", n, sa_if.overflow, sa_if.underflow, exp_ovf, exp_udf); end
      vectors++; if (rg_if.q !== rq_exp) begin miscompares++; $display("FAIL rnd_qreg@%0d: got %h want %h", n, rg_if.q, rq_exp); end
      if (mq.size() != 0) begin
        vectors++; if (sa_if.q !== mq[0]) begin miscompares++; $display("FAIL rnd_head@%0d: got %h want %h", n, sa_if.q, mq[0]); end
      end
    end
  endtask

  initial begin
    aclr  = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;
    test_reset();
    test_fill_overflow();
    test_back_to_back_wrap();
    test_showahead();
    test_underflow();
    test_reset_mid();
    test_registered();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
